ir_nec_decoder: RTL and testbench



---
 rtl/ir_nec_decoder.sv | 212 +++++++++++++++++++++
 tb/tb_ir_nec_decoder.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ir_nec_decoder.sv
// NEC IR decoder: tick-timed mark/space measurement, 32-bit frame check, command hold (IR_REPEAT_EN adds repeat frames).
// Pulses appear 4 clk_50 cycles after the ir_rx edge that ends a frame; no backpressure, outputs are free-running.
module ir_nec_decoder #(
    parameter int TICK_DIV      = 500,
    parameter int HOLD_TICKS    = 12000,
    parameter int TIMEOUT_TICKS = 1100
) (
    input  logic       clk_50,
    input  logic       reset_n,
    input  logic       ir_rx,
    output logic [7:0] IR_button,
    output logic [7:0] addr,
    output logic       code_valid,
    output logic       repeat_pulse,
    output logic       frame_error,
    output logic       busy
);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = $clog2(TIMEOUT_TICKS + 1);
    localparam int HW = $clog2(HOLD_TICKS + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DUR_MAX   = DW'(TIMEOUT_TICKS);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_TICKS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD_MARK,
        ST_LEAD_SPACE,
        ST_BIT_MARK,
        ST_BIT_SPACE,
        ST_REP_MARK
    } state_t;

    logic          r_sync1, r_sync2, r_sync3;
    logic          r_fall, r_rise;
    logic [TW-1:0] r_tick_cnt;
    logic [DW-1:0] r_dur;
    state_t        r_state;
    logic [5:0]    r_bitcnt;
    logic [31:0]   r_sr;
    logic [HW-1:0] r_hold;
    logic [7:0]    r_button;
    logic [7:0]    r_addr;
    logic          r_code_valid;
    logic          r_repeat;
    logic          r_error;

    logic          w_tick;
    logic          w_edge;
    logic [31:0]   w_dur;
    logic          w_unused_addr_inv;

    function automatic logic in_win(input logic [31:0] d, input logic [31:0] lo, input logic [31:0] hi);
        return (d >= lo) && (d <= hi);
    endfunction

    assign w_tick = (r_tick_cnt == TICK_LAST);
    assign w_edge = r_fall | r_rise;
    assign w_dur  = 32'(r_dur);
    // The address inverse byte is carried through the shifter but never checked.
    assign w_unused_addr_inv = ^r_sr[15:8];

    assign IR_button    = r_button;
    assign addr         = r_addr;
    assign code_valid   = r_code_valid;
    assign repeat_pulse = r_repeat;
    assign frame_error  = r_error;
    assign busy         = (r_state != ST_IDLE);

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_sync3 <= 1'b1;
            r_fall  <= 1'b0;
            r_rise  <= 1'b0;
        end else begin
            r_sync1 <= ir_rx;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            r_fall  <= r_sync3 & ~r_sync2;
            r_rise  <= ~r_sync3 & r_sync2;
        end
    end

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_tick_cnt <= '0;
            r_dur      <= '0;
        end else begin
            if (w_tick) r_tick_cnt <= '0;
            else        r_tick_cnt <= r_tick_cnt + 1'b1;
            if (w_edge)
                r_dur <= '0;
            else if (w_tick && (r_dur != DUR_MAX))
                r_dur <= r_dur + 1'b1;
        end
    end

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_bitcnt     <= '0;
            r_sr         <= '0;
            r_hold       <= '0;
            r_button     <= 8'h00;
            r_addr       <= 8'h00;
            r_code_valid <= 1'b0;
            r_repeat     <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_code_valid <= 1'b0;
            r_repeat     <= 1'b0;
            r_error      <= 1'b0;

            // Frame decode below is later in the block, so a new command beats a same-cycle expiry.
            if (w_tick && (r_hold != '0)) begin
                r_hold <= r_hold - 1'b1;
                if (r_hold == HW'(1)) r_button <= 8'h00;
            end

            if ((r_state != ST_IDLE) && !w_edge && (r_dur == DUR_MAX)) begin
                r_error <= 1'b1;
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (r_fall) r_state <= ST_LEAD_MARK;
                    end
                    ST_LEAD_MARK: begin
                        if (r_rise) begin
                            if (in_win(w_dur, 32'd800, 32'd1000)) begin
                                r_state <= ST_LEAD_SPACE;
                            end else begin
                                r_error <= 1'b1;
                                r_state <= ST_IDLE;
                            end
                        end
                    end
                    ST_LEAD_SPACE: begin
                        if (r_fall) begin
                            if (in_win(w_dur, 32'd400, 32'd500)) begin
                                r_bitcnt <= '0;
                                r_state  <= ST_BIT_MARK;
                            end
`ifdef IR_REPEAT_EN
                            else if (in_win(w_dur, 32'd180, 32'd270)) begin
                                r_state <= ST_REP_MARK;
                            end
`endif
                            else begin
                                r_error <= 1'b1;
                                r_state <= ST_IDLE;
                            end
                        end
                    end
                    ST_BIT_MARK: begin
                        if (r_rise) begin
                            if (!in_win(w_dur, 32'd40, 32'd75)) begin
                                r_error <= 1'b1;
                                r_state <= ST_IDLE;
                            end else if (r_bitcnt == 6'd32) begin
                                r_state <= ST_IDLE;
                                if (r_sr[31:24] == ~r_sr[23:16]) begin
                                    r_button     <= r_sr[23:16];
                                    r_addr       <= r_sr[7:0];
                                    r_code_valid <= 1'b1;
                                    r_hold       <= HOLD_LOAD;
                                end else begin
                                    r_error <= 1'b1;
                                end
                            end else begin
                                r_state <= ST_BIT_SPACE;
                            end
                        end
                    end
                    ST_BIT_SPACE: begin
                        if (r_fall) begin
                            if (in_win(w_dur, 32'd40, 32'd90)) begin
                                r_sr     <= {1'b0, r_sr[31:1]};
                                r_bitcnt <= r_bitcnt + 1'b1;
                                r_state  <= ST_BIT_MARK;
                            end else if (in_win(w_dur, 32'd130, 32'd210)) begin
                                r_sr     <= {1'b1, r_sr[31:1]};
                                r_bitcnt <= r_bitcnt + 1'b1;
                                r_state  <= ST_BIT_MARK;
                            end else begin
                                r_error <= 1'b1;
                                r_state <= ST_IDLE;
                            end
                        end
                    end
`ifdef IR_REPEAT_EN
                    ST_REP_MARK: begin
                        if (r_rise) begin
                            r_state <= ST_IDLE;
                            if (!in_win(w_dur, 32'd40, 32'd75)) begin
                                r_error <= 1'b1;
                            end else if (r_hold != '0) begin
                                r_repeat <= 1'b1;
                                r_hold   <= HOLD_LOAD;
                                r_button <= r_button;
                            end
                        end
                    end
`endif
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ir_nec_decoder.sv
// Directed bench for ir_nec_decoder: frame table plus hand-written hold, leader, reset, repeat and timeout sequences.
// Runs with one clock per tick so full NEC frames fit a short simulation.
module tb_ir_nec_decoder;
    localparam int HOLD = 7000;
    localparam int TMO  = 1100;
    // Low/high lengths in cycles; the decoder measures each as (length - 1) ticks.
    localparam int L_LM = 901;
    localparam int L_LS = 451;
    localparam int L_RS = 226;
    localparam int L_M  = 51;
    localparam int L_S0 = 51;
    localparam int L_S1 = 141;

    logic       clk_50;
    logic       reset_n;
    logic       ir_rx;
    logic [7:0] IR_button;
    logic [7:0] addr;
    logic       code_valid;
    logic       repeat_pulse;
    logic       frame_error;
    logic       busy;

    ir_nec_decoder #(
        .TICK_DIV     (1),
        .HOLD_TICKS   (HOLD),
        .TIMEOUT_TICKS(TMO)
    ) dut (
        .clk_50      (clk_50),
        .reset_n     (reset_n),
        .ir_rx       (ir_rx),
        .IR_button   (IR_button),
        .addr        (addr),
        .code_valid  (code_valid),
        .repeat_pulse(repeat_pulse),
        .frame_error (frame_error),
        .busy        (busy)
    );

    initial clk_50 = 1'b0;
    always #5 clk_50 = ~clk_50;

    typedef struct {
        logic [31:0] frame;
        logic        ok;
        logic [7:0]  button;
        logic [7:0]  addr;
    } vec_t;

    vec_t vecs [6];

    int n_cmp = 0;
    int n_bad = 0;
    int cv_cnt, cv_at, fe_cnt, fe_at, rp_cnt, rp_at;
    int sp_fe_cnt, sp_fe_at;
    int tmo_at, tmo_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic lvl(input logic v, input int n);
        ir_rx = v;
        repeat (n) @(posedge clk_50);
        #1;
    endtask

    task automatic watch(input int n);
        cv_cnt = 0; cv_at = -1;
        fe_cnt = 0; fe_at = -1;
        rp_cnt = 0; rp_at = -1;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk_50);
            #1;
            if (code_valid === 1'b1)   begin cv_cnt++; if (cv_at < 0) cv_at = k; end
            if (frame_error === 1'b1)  begin fe_cnt++; if (fe_at < 0) fe_at = k; end
            if (repeat_pulse === 1'b1) begin rp_cnt++; if (rp_at < 0) rp_at = k; end
        end
    endtask

    // Ends with ir_rx just raised at the close of the stop mark.
    task automatic send_frame(input logic [31:0] w);
        lvl(1'b0, L_LM);
        lvl(1'b1, L_LS);
        for (int b = 0; b < 32; b++) begin
            lvl(1'b0, L_M);
            lvl(1'b1, w[b] ? L_S1 : L_S0);
        end
        lvl(1'b0, L_M);
        ir_rx = 1'b1;
    endtask

    // Leader, repeat-length space, mark; pulses around the space-ending fall land in sp_fe_*.
    task automatic send_repeat();
        lvl(1'b0, L_LM);
        lvl(1'b1, L_RS);
        ir_rx = 1'b0;
        watch(8);
        sp_fe_cnt = fe_cnt;
        sp_fe_at  = fe_at;
        repeat (L_M - 8) @(posedge clk_50);
        #1;
        ir_rx = 1'b1;
        watch(8);
    endtask

    initial begin
        vecs[0] = '{32'hF00FFF00, 1'b1, 8'h0f, 8'h00};
        vecs[1] = '{32'hED13FF00, 1'b0, 8'h0f, 8'h00};
        vecs[2] = '{32'hEF10125A, 1'b1, 8'h10, 8'h5a};
        vecs[3] = '{32'hEC13FE01, 1'b1, 8'h13, 8'h01};
        vecs[4] = '{32'h00FF7F80, 1'b1, 8'hff, 8'h80};
        vecs[5] = '{32'h0000FF00, 1'b0, 8'hff, 8'h80};

        reset_n = 1'b0;
        ir_rx   = 1'b1;
        repeat (5) @(posedge clk_50);
        #1;
        check("reset IR_button", 32'(IR_button), 32'h00);
        check("reset addr", 32'(addr), 32'h00);
        check("reset code_valid", 32'(code_valid), 32'h0);
        check("reset repeat_pulse", 32'(repeat_pulse), 32'h0);
        check("reset frame_error", 32'(frame_error), 32'h0);
        check("reset busy", 32'(busy), 32'h0);
        reset_n = 1'b1;
        repeat (10) @(posedge clk_50);
        #1;

        for (int i = 0; i < 6; i++) begin
            send_frame(vecs[i].frame);
            watch(8);
            check($sformatf("v%0d code_valid count", i), 32'(cv_cnt), vecs[i].ok ? 32'd1 : 32'd0);
            if (vecs[i].ok) check($sformatf("v%0d code_valid latency", i), 32'(cv_at), 32'd4);
            check($sformatf("v%0d frame_error count", i), 32'(fe_cnt), vecs[i].ok ? 32'd0 : 32'd1);
            if (!vecs[i].ok) check($sformatf("v%0d frame_error latency", i), 32'(fe_at), 32'd4);
            check($sformatf("v%0d repeat count", i), 32'(rp_cnt), 32'd0);
            check($sformatf("v%0d IR_button", i), 32'(IR_button), 32'(vecs[i].button));
            check($sformatf("v%0d addr", i), 32'(addr), 32'(vecs[i].addr));
            check($sformatf("v%0d busy", i), 32'(busy), 32'd0);
            repeat (20) @(posedge clk_50);
            #1;
        end

        // Hold expiry measured from the cycle code_valid is seen.
        send_frame(32'hEF10FF00);
        watch(4);
        check("hold code_valid latency", 32'(cv_at), 32'd4);
        check("hold IR_button set", 32'(IR_button), 32'h10);
        repeat (HOLD - 2) @(posedge clk_50);
        #1;
        check("hold IR_button before expiry", 32'(IR_button), 32'h10);
        repeat (3) @(posedge clk_50);
        #1;
        check("hold IR_button after expiry", 32'(IR_button), 32'h00);

        send_repeat();
`ifdef IR_REPEAT_EN
        check("idle repeat error", 32'(sp_fe_cnt + fe_cnt), 32'd0);
        check("idle repeat pulse", 32'(rp_cnt), 32'd0);
`else
        check("repeat space error count", 32'(sp_fe_cnt), 32'd1);
        check("repeat space error latency", 32'(sp_fe_at), 32'd4);
        check("repeat trailing mark ignored", 32'(fe_cnt + rp_cnt), 32'd0);
`endif
        check("after repeat IR_button", 32'(IR_button), 32'h00);
        check("after repeat busy", 32'(busy), 32'd0);

        // Short 600-tick leader, then an immediate good frame.
        lvl(1'b0, 601);
        ir_rx = 1'b1;
        watch(8);
        check("short leader error count", 32'(fe_cnt), 32'd1);
        check("short leader error latency", 32'(fe_at), 32'd4);
        check("short leader busy", 32'(busy), 32'd0);
        send_frame(32'hEC13FF00);
        watch(8);
        check("after short leader code_valid", 32'(cv_cnt), 32'd1);
        check("after short leader latency", 32'(cv_at), 32'd4);
        check("after short leader IR_button", 32'(IR_button), 32'h13);

`ifdef IR_REPEAT_EN
        for (int r = 0; r < 2; r++) begin
            repeat (5000) @(posedge clk_50);
            #1;
            send_repeat();
            check($sformatf("rep%0d pulse count", r), 32'(rp_cnt), 32'd1);
            check($sformatf("rep%0d pulse latency", r), 32'(rp_at), 32'd4);
            check($sformatf("rep%0d errors", r), 32'(sp_fe_cnt + fe_cnt), 32'd0);
            check($sformatf("rep%0d IR_button", r), 32'(IR_button), 32'h13);
        end
`endif

        // Reset asserted in the middle of bit 15.
        lvl(1'b0, L_LM);
        lvl(1'b1, L_LS);
        for (int b = 0; b < 15; b++) begin
            lvl(1'b0, L_M);
            lvl(1'b1, (b >= 8) ? L_S1 : L_S0);
        end
        lvl(1'b0, 20);
        check("mid-frame busy", 32'(busy), 32'd1);
        check("mid-frame IR_button", 32'(IR_button), 32'h13);
        #1;
        reset_n = 1'b0;
        #1;
        check("async reset IR_button", 32'(IR_button), 32'h00);
        check("async reset addr", 32'(addr), 32'h00);
        check("async reset busy", 32'(busy), 32'd0);
        check("async reset pulses", 32'({code_valid, repeat_pulse, frame_error}), 32'd0);
        ir_rx = 1'b1;
        repeat (5) @(posedge clk_50);
        #1;
        reset_n = 1'b1;
        watch(10);
        check("post-reset quiet", 32'(cv_cnt + fe_cnt + rp_cnt), 32'd0);
        check("post-reset busy", 32'(busy), 32'd0);
        send_frame(32'hF00FFF00);
        watch(8);
        check("post-reset code_valid", 32'(cv_cnt), 32'd1);
        check("post-reset latency", 32'(cv_at), 32'd4);
        check("post-reset IR_button", 32'(IR_button), 32'h0f);
        check("post-reset addr", 32'(addr), 32'h00);

        // Held low: duration reaches 1100 three cycles after the registered fall, error is registered one later.
        ir_rx   = 1'b0;
        tmo_at  = -1;
        tmo_cnt = 0;
        for (int k = 1; k <= TMO + 500; k++) begin
            @(posedge clk_50);
            #1;
            if (frame_error === 1'b1) begin
                tmo_cnt++;
                if (tmo_at < 0) tmo_at = k;
            end
        end
        check("timeout latency", 32'(tmo_at), 32'(TMO + 5));
        check("timeout error count", 32'(tmo_cnt), 32'd1);
        check("timeout busy", 32'(busy), 32'd0);
        ir_rx = 1'b1;
        watch(8);
        check("timeout rise ignored", 32'(fe_cnt + cv_cnt), 32'd0);
        check("timeout rise busy", 32'(busy), 32'd0);
        lvl(1'b0, 30);
        check("new fall busy", 32'(busy), 32'd1);
        ir_rx = 1'b1;
        watch(8);
        check("stub leader error", 32'(fe_cnt), 32'd1);
        check("stub leader busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
